// File: rtl/lpc_sniffer_pkg.sv
// -----------------------------------------------------------------------------
// lpc_sniffer_pkg
// Shared definitions for the LPC sniffer record path:
//   - state_e        : state encoding of the record transmitter FSM
//   - REC_W_DEFAULT  : default record width in bits (48)
//   - ASCII_CR/LF    : line terminator bytes appended in hex-ASCII mode
//   - ST_W           : width of the state encoding, used for debug outputs
// -----------------------------------------------------------------------------
package lpc_sniffer_pkg;

   localparam int REC_W_DEFAULT = 48;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_POP   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_LATCH = 3'd3,
      ST_SEND  = 3'd4
   } state_e;

endpackage : lpc_sniffer_pkg

// File: rtl/nibble_to_hex.sv
// -----------------------------------------------------------------------------
// nibble_to_hex
// Purely combinational conversion of a 4-bit value to its uppercase ASCII
// hex character ('0'-'9', 'A'-'F').
// Ports:
//   nibble_i  [3:0]  value to convert
//   ascii_o   [7:0]  ASCII code of the hex digit
// -----------------------------------------------------------------------------
module nibble_to_hex (
   input  logic [3:0] nibble_i,
   output logic [7:0] ascii_o
);

   always_comb begin
      ascii_o = 8'h30;
      if (nibble_i < 4'd10) begin
         ascii_o = 8'h30 + {4'h0, nibble_i};
      end else begin
         // 'A' is 0x41; nibble 10 maps to it.
         ascii_o = 8'h37 + {4'h0, nibble_i};
      end
   end

endmodule : nibble_to_hex

// File: rtl/lpc_record_tx.sv
// -----------------------------------------------------------------------------
// lpc_record_tx
// Pops fixed-width records from a ring buffer and streams them byte by byte
// to a UART transmitter, most significant byte first.
//
// Build option: define HEX_ASCII_EN to send each record as 2*NB uppercase
// ASCII hex characters followed by CR, LF. Without it, NB raw bytes are sent
// with no terminator.
//
// Parameters:
//   DW  record width in bits (multiple of 8)
//   NB  bytes per record, derived as DW/8
// Ports:
//   clock              single clock, rising edge
//   reset              asynchronous active-low reset
//   empty              ring buffer holds no record
//   overflow           ring buffer full and dropping writes
//   read_data [DW-1:0] record at the ring buffer read pointer
//   read_clock_enable  one-cycle pop strobe to the ring buffer
//   tx_data   [7:0]    byte to the UART transmitter
//   tx_valid           tx_data holds a valid byte
//   tx_ready           transmitter accepts tx_data this cycle
//   busy               high in every state except IDLE
//   lost               sticky: overflow seen since reset
//   dbg_state_o        current FSM state encoding
//
// Handshake: a byte moves on a rising edge where tx_valid and tx_ready are
// both high. Once tx_valid rises it stays high, with tx_data unchanged, until
// that transfer happens; tx_ready while tx_valid is low is ignored.
// -----------------------------------------------------------------------------
module lpc_record_tx
   import lpc_sniffer_pkg::*;
#(
   parameter  int DW = REC_W_DEFAULT,
   localparam int NB = DW / 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            empty,
   input  logic            overflow,
   input  logic [DW-1:0]   read_data,
   output logic            read_clock_enable,
   output logic [7:0]      tx_data,
   output logic            tx_valid,
   input  logic            tx_ready,
   output logic            busy,
   output logic            lost,
   output logic [ST_W-1:0] dbg_state_o
);

`ifdef HEX_ASCII_EN
   // Two characters per byte plus CR and LF.
   localparam int FRAME = 2 * NB + 2;
   // The shift register advances one nibble per character.
   localparam int STEP  = 4;
`else
   localparam int FRAME = NB;
   localparam int STEP  = 8;
`endif

   // Counter just wide enough to index every byte of a frame.
   localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

   state_e          state_q, state_d;
   logic [DW-1:0]   shift_q, shift_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic            lost_q,  lost_d;
   // Low for the first edge after reset release so the earliest POP is
   // entered on the second rising edge.
   logic            armed_q, armed_d;

   logic [7:0]      cur_byte;

   // --------------------------------------------------------------------------
   // Byte currently presented to the transmitter
   // --------------------------------------------------------------------------
`ifdef HEX_ASCII_EN
   localparam logic [CW-1:0] CR_IDX = CW'(2 * NB);

   logic [7:0] hex_char;

   nibble_to_hex u_nibble_to_hex (
      .nibble_i (shift_q[DW-1 -: 4]),
      .ascii_o  (hex_char)
   );

   always_comb begin
      cur_byte = hex_char;
      if (cnt_q == CR_IDX) begin
         cur_byte = ASCII_CR;
      end else if (cnt_q == LAST_IDX) begin
         cur_byte = ASCII_LF;
      end
   end
`else
   always_comb begin
      cur_byte = shift_q[DW-1 -: 8];
   end
`endif

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         lost_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         lost_q  <= lost_d;
         armed_q <= armed_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and output logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d           = state_q;
      shift_d           = shift_q;
      cnt_d             = cnt_q;
      armed_d           = 1'b1;
      lost_d            = lost_q | overflow;
      read_clock_enable = 1'b0;
      tx_valid          = 1'b0;
      tx_data           = 8'h00;

      unique case (state_q)
         ST_IDLE: begin
            if (armed_q && !empty) begin
               state_d = ST_POP;
            end
         end

         ST_POP: begin
            read_clock_enable = 1'b1;
            state_d           = ST_WAIT;
         end

         // Buffer presents the popped record one cycle after the strobe.
         ST_WAIT: begin
            state_d = ST_LATCH;
         end

         ST_LATCH: begin
            shift_d = read_data;
            cnt_d   = '0;
            state_d = ST_SEND;
         end

         ST_SEND: begin
            tx_valid = 1'b1;
            tx_data  = cur_byte;
            if (tx_ready) begin
               if (cnt_q == LAST_IDX) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  // In hex mode this keeps shifting through CR/LF; the zeros
                  // shifted in are never presented.
                  shift_d = shift_q << STEP;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy        = (state_q != ST_IDLE);
   assign lost        = lost_q;
   assign dbg_state_o = state_q;

endmodule : lpc_record_tx
